// File: rtl/text_write_queue_pkg.sv
// Shared constants, FSM encoding and address helper for the text write queue.
package text_write_queue_pkg;

  localparam int unsigned TEXTCOLS_CHAR   = 80;
  localparam int unsigned TEXTROWS_CHAR   = 30;
  localparam int unsigned TEXT_ADDR_WIDTH = 12;
  localparam int unsigned CHARATTR_WIDTH  = 24;
  localparam int unsigned FIFO_DEPTH_LOG2 = 2;

  // Write sequencer states:
  //   ST_IDLE  | waiting for a queued entry; pops the head when one is present
  //   ST_CALC  | one cycle: builds the linear address and loads the data word
  //   ST_WRITE | ram_we high, address/data held until the arbiter grants
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_WRITE = 2'd2
  } wq_state_t;

  // Row-major linear address; COLS is a constant so this folds into shifts/adds.
  function automatic logic [31:0] linear_addr(input logic [7:0] x,
                                              input logic [7:0] y,
                                              input int unsigned cols);
    return 32'(y) * cols + 32'(x);
  endfunction

endpackage

// File: rtl/text_write_fifo.sv
// Small synchronous FIFO; push on full and pop on empty are ignored.
module text_write_fifo #(
  parameter int unsigned WIDTH      = 40,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  push_ok;
  logic                  pop_ok;

  assign full      = (count == DEPTH_CNT);
  assign empty     = (count == '0);
  assign level     = count;
  assign head_data = mem[rd_ptr];
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;

  // Storage array: written at the tail on an accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push_ok && !pop_ok) begin
        count <= count + CNT_ONE;
      end else if (pop_ok && !push_ok) begin
        count <= count - CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/text_write_queue.sv
// Queues character writes from the register file and issues them to the
// text RAM one at a time, only on arbiter-granted slots.
module text_write_queue
  import text_write_queue_pkg::*;
#(
  parameter int unsigned COLS       = TEXTCOLS_CHAR,
  parameter int unsigned ROWS       = TEXTROWS_CHAR,
  parameter int unsigned ADDR_W     = TEXT_ADDR_WIDTH,
  parameter int unsigned DATA_W     = CHARATTR_WIDTH,
  parameter int unsigned DEPTH_LOG2 = FIFO_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  character_change,
  input  logic [7:0]            xtext,
  input  logic [7:0]            ytext,
  input  logic [DATA_W-1:0]     charattr,
  input  logic                  ram_grant,
  output logic                  ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_data,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  busy,
  output logic                  range_error,
  output logic                  overflow
);

  localparam int unsigned ENTRY_W = DATA_W + 16;

  wq_state_t           state_q;
  wq_state_t           state_d;
  logic                in_range;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [ENTRY_W-1:0]  fifo_head;
  logic [7:0]          hold_x;
  logic [7:0]          hold_y;
  logic [DATA_W-1:0]   hold_data;
  logic                we_d;
  logic                calc_load;

  assign in_range  = (32'(xtext) < COLS) && (32'(ytext) < ROWS);
  assign fifo_push = character_change && in_range;
  assign busy      = !fifo_empty || (state_q != ST_IDLE);

  text_write_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data ({xtext, ytext, charattr}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Push-side status: range errors pulse for one cycle, overflow is sticky.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      range_error <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      range_error <= character_change && !in_range;
      if (fifo_push && fifo_full) begin
        overflow <= 1'b1;
      end
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, pop request and next write-enable.
  always_comb begin
    state_d   = state_q;
    fifo_pop  = 1'b0;
    we_d      = ram_we;
    calc_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_CALC;
        end
      end
      ST_CALC: begin
        calc_load = 1'b1;
        we_d      = 1'b1;
        state_d   = ST_WRITE;
      end
      ST_WRITE: begin
        if (ram_we && ram_grant) begin
          we_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        we_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Popped entry holding register; the FIFO head is only valid in the pop cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_x    <= '0;
      hold_y    <= '0;
      hold_data <= '0;
    end else if (fifo_pop) begin
      hold_x    <= fifo_head[ENTRY_W-1 -: 8];
      hold_y    <= fifo_head[DATA_W+7 -: 8];
      hold_data <= fifo_head[DATA_W-1:0];
    end
  end

  // RAM-side outputs; address and data change only when an entry enters WRITE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
    end else begin
      ram_we <= we_d;
      if (calc_load) begin
        ram_addr <= ADDR_W'(linear_addr(hold_x, hold_y, COLS));
        ram_data <= hold_data;
      end
    end
  end

endmodule

// File: tb/tb_text_write_queue.sv
// Directed bench for text_write_queue.
module tb_text_write_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        character_change;
  logic [7:0]  xtext;
  logic [7:0]  ytext;
  logic [23:0] charattr;
  logic        ram_grant;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [23:0] ram_data;
  logic [2:0]  fifo_level;
  logic        busy;
  logic        range_error;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  logic [11:0] wr_log[$];
  int          we_cycles;

  text_write_queue dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .character_change (character_change),
    .xtext            (xtext),
    .ytext            (ytext),
    .charattr         (charattr),
    .ram_grant        (ram_grant),
    .ram_we           (ram_we),
    .ram_addr         (ram_addr),
    .ram_data         (ram_data),
    .fifo_level       (fifo_level),
    .busy             (busy),
    .range_error      (range_error),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  // Record every completed write (we && grant) mid-cycle, away from the edge.
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      we_cycles++;
      if (ram_grant === 1'b1) wr_log.push_back(ram_addr);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n          = 1'b0;
    character_change = 1'b0;
    xtext            = '0;
    ytext            = '0;
    charattr         = '0;
    ram_grant        = 1'b0;
    tick(2);
    reset_n = 1'b1;
    wr_log.delete();
    we_cycles = 0;
  endtask

  task automatic strobe(input logic [7:0] x, input logic [7:0] y, input logic [23:0] d);
    character_change = 1'b1;
    xtext            = x;
    ytext            = y;
    charattr         = d;
    tick();
    character_change = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ram_we, ram_addr, ram_data, fifo_level, range_error, overflow, busy} !== '0) begin
      failures++;
      $display("FAIL reset_state: we=%b addr=%0d data=%h lvl=%0d rerr=%b ovf=%b busy=%b, required all zero",
               ram_we, ram_addr, ram_data, fifo_level, range_error, overflow, busy);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    ram_grant = 1'b1;
    strobe(8'd5, 8'd2, 24'h0F1E41);
    checks++;
    if (fifo_level !== 3'd1 || busy !== 1'b1 || ram_we !== 1'b0) begin
      failures++;
      $display("FAIL single_after_push: lvl=%0d busy=%b we=%b, required 1 1 0", fifo_level, busy, ram_we);
    end
    tick();
    checks++;
    if (ram_we !== 1'b0) begin
      failures++;
      $display("FAIL single_early_we: we=%b, required 0", ram_we);
    end
    tick();
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== 12'd165 || ram_data !== 24'h0F1E41) begin
      failures++;
      $display("FAIL single_write: we=%b addr=%0d data=%h, required 1 165 0f1e41", ram_we, ram_addr, ram_data);
    end
    tick();
    checks++;
    if (ram_we !== 1'b0 || busy !== 1'b0 || fifo_level !== 3'd0) begin
      failures++;
      $display("FAIL single_done: we=%b busy=%b lvl=%0d, required 0 0 0", ram_we, busy, fifo_level);
    end
    tick(4);
    checks++;
    if (we_cycles !== 1 || wr_log.size() !== 1) begin
      failures++;
      $display("FAIL single_count: we_cycles=%0d writes=%0d, required 1 1", we_cycles, wr_log.size());
    end
  endtask

  task automatic test_corner_addr();
    do_reset();
    ram_grant = 1'b1;
    strobe(8'd79, 8'd29, 24'h123456);
    strobe(8'd0, 8'd0, 24'h654321);
    tick(12);
    checks++;
    if (wr_log.size() !== 2) begin
      failures++;
      $display("FAIL corner_count: writes=%0d, required 2", wr_log.size());
    end else begin
      checks++;
      if (wr_log[0] !== 12'd2399 || wr_log[1] !== 12'd0) begin
        failures++;
        $display("FAIL corner_addr: got %0d,%0d, required 2399,0", wr_log[0], wr_log[1]);
      end
    end
  endtask

  // The first entry is popped one cycle after its push, so four more strobes
  // fill the 4-deep FIFO and only a sixth one overflows.
  task automatic test_back_pressure();
    do_reset();
    for (int i = 0; i < 5; i++) strobe(8'(i), 8'd0, 24'(i));
    tick(3);
    checks++;
    if (fifo_level !== 3'd4 || overflow !== 1'b0 || ram_we !== 1'b1) begin
      failures++;
      $display("FAIL bp_fill: lvl=%0d ovf=%b we=%b, required 4 0 1", fifo_level, overflow, ram_we);
    end
    strobe(8'd5, 8'd0, 24'd5);
    tick();
    checks++;
    if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL bp_overflow: lvl=%0d ovf=%b, required 4 1", fifo_level, overflow);
    end
    ram_grant = 1'b1;
    tick(25);
    checks++;
    if (wr_log.size() !== 5) begin
      failures++;
      $display("FAIL bp_count: writes=%0d, required 5", wr_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (wr_log[i] !== 12'(i)) begin
          failures++;
          $display("FAIL bp_order[%0d]: addr=%0d, required %0d", i, wr_log[i], i);
        end
      end
    end
    checks++;
    if (overflow !== 1'b1 || fifo_level !== 3'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_final: ovf=%b lvl=%0d busy=%b, required 1 0 0", overflow, fifo_level, busy);
    end
  endtask

  task automatic test_range();
    do_reset();
    ram_grant = 1'b1;
    strobe(8'd80, 8'd0, 24'hAAAAAA);
    checks++;
    if (range_error !== 1'b1) begin
      failures++;
      $display("FAIL range_x: rerr=%b, required 1", range_error);
    end
    strobe(8'd0, 8'd30, 24'hBBBBBB);
    checks++;
    if (range_error !== 1'b1) begin
      failures++;
      $display("FAIL range_y: rerr=%b, required 1", range_error);
    end
    tick();
    checks++;
    if (range_error !== 1'b0) begin
      failures++;
      $display("FAIL range_pulse: rerr=%b, required 0", range_error);
    end
    tick(6);
    checks++;
    if (we_cycles !== 0 || fifo_level !== 3'd0 || overflow !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL range_quiet: we_cycles=%0d lvl=%0d ovf=%b busy=%b, required 0 0 0 0",
               we_cycles, fifo_level, overflow, busy);
    end
  endtask

  task automatic test_stall();
    logic stable;
    do_reset();
    strobe(8'd10, 8'd3, 24'hABCDEF);
    tick(2);
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== 12'd250 || ram_data !== 24'hABCDEF) begin
      failures++;
      $display("FAIL stall_enter: we=%b addr=%0d data=%h, required 1 250 abcdef", ram_we, ram_addr, ram_data);
    end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ram_we !== 1'b1 || ram_addr !== 12'd250 || ram_data !== 24'hABCDEF) stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin
      failures++;
      $display("FAIL stall_hold: outputs changed, last we=%b addr=%0d data=%h", ram_we, ram_addr, ram_data);
    end
    ram_grant = 1'b1;
    tick();
    ram_grant = 1'b0;
    checks++;
    if (ram_we !== 1'b0 || busy !== 1'b0 || wr_log.size() !== 1) begin
      failures++;
      $display("FAIL stall_release: we=%b busy=%b writes=%0d, required 0 0 1", ram_we, busy, wr_log.size());
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    strobe(8'd1, 8'd1, 24'h111111);
    strobe(8'd2, 8'd1, 24'h222222);
    strobe(8'd3, 8'd1, 24'h333333);
    checks++;
    if (ram_we !== 1'b1 || fifo_level !== 3'd2) begin
      failures++;
      $display("FAIL midrst_setup: we=%b lvl=%0d, required 1 2", ram_we, fifo_level);
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++;
    if ({ram_we, ram_addr, ram_data, fifo_level, range_error, overflow, busy} !== '0) begin
      failures++;
      $display("FAIL midrst_state: we=%b addr=%0d data=%h lvl=%0d rerr=%b ovf=%b busy=%b, required all zero",
               ram_we, ram_addr, ram_data, fifo_level, range_error, overflow, busy);
    end
    ram_grant = 1'b1;
    we_cycles = 0;
    tick(15);
    checks++;
    if (we_cycles !== 0) begin
      failures++;
      $display("FAIL midrst_nowrite: we_cycles=%0d, required 0", we_cycles);
    end
  endtask

  initial begin
    we_cycles = 0;
    test_reset();
    test_single_write();
    test_corner_addr();
    test_back_pressure();
    test_range();
    test_stall();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
